i2s_sample_port: RTL and testbench
==================================

# i2s_sample_port

Serial audio front/back end for the DSP engine. Deserialises the left slot of an I2S stream into a parallel sample with a one-cycle `sample_valid` strobe that drives the engine's `in_sample`/`sample_valid`. Captures the engine's `out_sample` when its `ready` rises and serialises it into the next frame's left slot on `i2s_sdout`. All I2S pins are asynchronous to `clk` and are oversampled.

## Interface
- `data_width`, 16: sample width in bits, both directions.
- `slot_bits`, 32: nominal bits per channel slot; sizes the bit counter to `$clog2(slot_bits)+1` bits.

- `clk` in 1: system clock; must be ≥ 8× `i2s_bclk`.
- `reset` in 1: asynchronous, active-low reset.
- `i2s_bclk` in 1: I2S bit clock, asynchronous.
- `i2s_lrclk` in 1: word select, asynchronous; low = left.
- `i2s_sdin` in 1: serial data from ADC.
- `i2s_sdout` out 1: serial data to DAC.
- `in_sample` out `data_width`: last captured left sample, signed.
- `sample_valid` out 1: one-cycle strobe; `in_sample` is new.
- `out_sample` in `data_width`: processed sample from the engine.
- `engine_ready` in 1: engine `ready`; its rising edge marks `out_sample` valid.
- `underrun` out 1: one-cycle pulse when a frame starts with no new `out_sample`.

## Operation
- Each of `i2s_bclk`, `i2s_lrclk` and `i2s_sdin` passes through a 2-flop synchroniser, then one history register. A rise or fall of the synchronised `bclk` raises one-cycle internal `b_rise` / `b_fall`.
- On each `b_rise`, sample `lrclk_s` and `sdin_s`, and keep `lrclk_prev`.
- Receive FSM:
  - IDLE: wait for a `b_rise` with `lrclk_prev`=1 and `lrclk_s`=0. That rise is the I2S delay bit. Clear `bit_cnt`, clear `rx_shift`, load `tx_shift`, go to LEFT.
  - LEFT: on each `b_rise`, shift `sdin_s` into the `rx_shift` LSB, MSB first, and increment `bit_cnt`.
    - At `bit_cnt`=`data_width`: copy to `in_sample`, pulse `sample_valid`, go to SKIP.
    - If `lrclk_s`=1 is seen first (short slot): left-justify the bits received, zero-fill the LSBs, emit as above, go to SKIP.
  - SKIP: ignore data. Return to LEFT processing on the next `lrclk` 1→0 delay bit, handled exactly as in IDLE.
- Slot bits beyond `data_width` are ignored.
- Leaving IDLE requires a clean 1→0 `lrclk` transition; after reset the first partial frame is discarded.
- Transmit path:
  - `engine_ready` is edge-detected, no synchroniser (same clock domain).
  - On its rising edge, `tx_hold` ← `out_sample` and `tx_fresh` ← 1.
  - At each delay-bit `b_rise`: `tx_shift` ← `tx_hold`, `tx_fresh` ← 0.
    - If `tx_fresh` was 0, pulse `underrun`. `tx_hold` keeps its old value, so the previous sample repeats.
    - A `tx_hold` load and a delay bit in the same cycle: the delay bit loads the new `out_sample` directly and no underrun is raised.
  - On each `b_fall`: `i2s_sdout` ← `tx_shift` MSB, then shift left with zero fill. The MSB therefore appears on the first falling edge after the delay bit.
  - After `data_width` bits, `i2s_sdout` is 0 for the remainder of the left slot. Right-slot content is set by the macro under Configuration.

## Timing
- Reset values:
  - `in_sample`=0, `sample_valid`=0, `i2s_sdout`=0, `underrun`=0.
  - `tx_hold`=0, `tx_fresh`=0, FSM=IDLE, synchronisers=0.
- Reset is asserted asynchronously and released synchronously through a 2-flop reset synchroniser.
- Reset mid-frame: all state is lost and the block re-enters IDLE. No partial `sample_valid` is emitted.
- Pin-to-edge latency: 3 `clk` (2 synchroniser stages + 1 history register).
- `sample_valid` is high exactly 1 `clk`, in the cycle after the `b_rise` that captures the LSB (or sees the early `lrclk`). `in_sample` is stable from that cycle until the next strobe.
- At most one `sample_valid` per `lrclk` frame.
- `underrun` is high exactly 1 `clk`, in the cycle after the delay-bit `b_rise`.
- `i2s_sdout` changes only in the cycle after a `b_fall`.

## Configuration
- `I2S_OUT_DUP_EN`:
  - Defined: at the right-slot delay bit (`lrclk` 0→1 `b_rise`), `tx_shift` is reloaded with the same `tx_hold`, so the right slot carries a copy of the left sample (mono to both DAC channels). This reload never pulses `underrun` and never clears `tx_fresh`.
  - Undefined: `i2s_sdout` is 0 throughout the right slot.

## Test plan
- 32-bit slots, `bclk` = `clk`/16, left word 0x8123 → `in_sample`=0x8123. One `sample_valid` per frame, 3 `clk` + 1 after the LSB `b_rise`.
- Short slot, `lrclk` rises after 12 bits 0xABC → `in_sample`=0xABC0, single `sample_valid`.
- `engine_ready` rise with `out_sample`=0x5A5A before the frame → left slot on `sdout` = 0x5A5A MSB-first, then zeros; `underrun` stays 0.
- No `engine_ready` rise between two frames → second frame repeats the previous word and `underrun` pulses once.
- Assert `reset`=0 mid-left-slot, release → no `sample_valid` for the interrupted frame. First strobe follows the next full 1→0 `lrclk` frame; all outputs are 0 during reset.
- With `I2S_OUT_DUP_EN`, `out_sample`=0x1234 → both slots carry 0x1234. Without it, the right slot is all 0.

Source files
------------

// File: rtl/i2s_sample_port.sv
// i2s_sample_port
//   Serial audio front/back end for the DSP engine.
//   Receive: deserialises the left slot of an oversampled I2S stream into a
//   parallel signed sample with a one-cycle sample_valid strobe.
//   Transmit: captures out_sample on the rising edge of engine_ready and
//   serialises it MSB-first into the next frame's left slot on i2s_sdout.
//
// Configuration macro:
//   I2S_OUT_DUP_EN  defined   : right slot repeats the left sample (mono to both DAC channels)
//                   undefined : i2s_sdout is 0 throughout the right slot
//
// Ports:
//   clk           system clock, at least 8x i2s_bclk
//   reset         asynchronous active-low reset (released through a 2-flop synchroniser)
//   i2s_bclk      I2S bit clock (asynchronous)
//   i2s_lrclk     I2S word select, low = left (asynchronous)
//   i2s_sdin      serial data from ADC (asynchronous)
//   i2s_sdout     serial data to DAC, updated after each bclk fall
//   in_sample     last captured left sample, signed
//   sample_valid  one-cycle strobe, in_sample is new
//   out_sample    processed sample from the engine
//   engine_ready  engine ready; rising edge marks out_sample valid
//   underrun      one-cycle pulse when a frame starts with no new out_sample
//
// Receive FSM:
//   state   | meaning
//   IDLE    | after reset, waiting for the first clean lrclk 1->0 delay bit
//   LEFT    | shifting left-slot data bits, MSB first
//   SKIP    | ignoring slot bits until the next left delay bit

module i2s_sample_port #(
  parameter int data_width = 16,
  parameter int slot_bits  = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i2s_bclk,
  input  logic                         i2s_lrclk,
  input  logic                         i2s_sdin,
  output logic                         i2s_sdout,
  output logic signed [data_width-1:0] in_sample,
  output logic                         sample_valid,
  input  logic        [data_width-1:0] out_sample,
  input  logic                         engine_ready,
  output logic                         underrun
);

  localparam int               cnt_w     = $clog2(slot_bits) + 1;
  localparam logic [cnt_w-1:0] last_bit  = cnt_w'(data_width - 1);
  localparam logic [cnt_w-1:0] width_cnt = cnt_w'(data_width);

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_left = 2'd1,
    st_skip = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Reset synchroniser: assert asynchronously, release on clk
  // ---------------------------------------------------------------------
  logic [1:0] rst_pipe;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_n = rst_pipe[1];

  // ---------------------------------------------------------------------
  // Pin synchronisers: [0],[1] synchronise, [2] is the history stage
  // ---------------------------------------------------------------------
  logic [2:0] bclk_sr;
  logic [2:0] lrclk_sr;
  logic [2:0] sdin_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_sr  <= '0;
      lrclk_sr <= '0;
      sdin_sr  <= '0;
    end else begin
      bclk_sr  <= {bclk_sr[1:0],  i2s_bclk};
      lrclk_sr <= {lrclk_sr[1:0], i2s_lrclk};
      sdin_sr  <= {sdin_sr[1:0],  i2s_sdin};
    end
  end

  logic b_rise;
  logic b_fall;
  logic lrclk_s;
  logic sdin_s;

  assign b_rise  =  bclk_sr[1] & ~bclk_sr[2];
  assign b_fall  = ~bclk_sr[1] &  bclk_sr[2];
  assign lrclk_s = lrclk_sr[2];
  assign sdin_s  = sdin_sr[2];

  // Word select as seen on the previous bclk rise; a change between two
  // rises marks the delay bit of the slot that is starting.
  logic lrclk_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      lrclk_prev <= 1'b0;
    else if (b_rise) lrclk_prev <= lrclk_s;
  end

  logic left_delay;
  logic right_delay;

  assign left_delay  = b_rise &  lrclk_prev & ~lrclk_s;
  assign right_delay = b_rise & ~lrclk_prev &  lrclk_s;

  // ---------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------
  state_t           state;
  state_t           state_nxt;
  logic [cnt_w-1:0] bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= st_idle;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      st_idle, st_skip: begin
        if (left_delay) state_nxt = st_left;
      end
      st_left: begin
        if (b_rise && (lrclk_s || (bit_cnt == last_bit))) state_nxt = st_skip;
      end
      default: state_nxt = st_idle;
    endcase
  end

  logic rx_start;
  logic rx_shift_en;
  logic rx_done_full;
  logic rx_done_short;

  always_comb begin
    rx_start      = 1'b0;
    rx_shift_en   = 1'b0;
    rx_done_full  = 1'b0;
    rx_done_short = 1'b0;
    case (state)
      st_idle, st_skip: begin
        rx_start = left_delay;
      end
      st_left: begin
        if (b_rise) begin
          // lrclk already high means the slot ended before data_width bits
          if (lrclk_s) begin
            rx_done_short = 1'b1;
          end else begin
            rx_shift_en  = 1'b1;
            rx_done_full = (bit_cnt == last_bit);
          end
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Receive datapath
  // ---------------------------------------------------------------------
  logic [data_width-1:0] rx_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt      <= '0;
      rx_shift     <= '0;
      in_sample    <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= rx_done_full | rx_done_short;
      if (rx_start) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (rx_shift_en) begin
        rx_shift <= {rx_shift[data_width-2:0], sdin_s};
        bit_cnt  <= bit_cnt + cnt_w'(1);
      end
      if (rx_done_full) begin
        in_sample <= $signed({rx_shift[data_width-2:0], sdin_s});
      end else if (rx_done_short) begin
        // left-justify the bits of a short slot, zero-filling the LSBs
        in_sample <= $signed(rx_shift << (width_cnt - bit_cnt));
      end
    end
  end

  // ---------------------------------------------------------------------
  // Transmit path
  // ---------------------------------------------------------------------
  logic                  ready_d;
  logic                  ready_rise;
  logic [data_width-1:0] tx_hold;
  logic                  tx_fresh;
  logic [data_width-1:0] tx_shift;
  logic [data_width-1:0] right_load;

  // engine_ready is generated on clk, so a plain edge detector suffices
  assign ready_rise = engine_ready & ~ready_d;

`ifdef I2S_OUT_DUP_EN
  assign right_load = tx_hold;
`else
  assign right_load = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_d   <= 1'b0;
      tx_hold   <= '0;
      tx_fresh  <= 1'b0;
      tx_shift  <= '0;
      i2s_sdout <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      ready_d  <= engine_ready;
      underrun <= 1'b0;
      if (ready_rise) tx_hold <= out_sample;
      if (left_delay) begin
        // A sample arriving on the delay bit itself is used straight away
        // and counts as consumed, so it neither underruns nor stays fresh.
        tx_shift <= ready_rise ? out_sample : tx_hold;
        tx_fresh <= 1'b0;
        underrun <= ~(tx_fresh | ready_rise);
      end else begin
        if (ready_rise) tx_fresh <= 1'b1;
        if (right_delay) begin
          tx_shift <= right_load;
        end else if (b_fall) begin
          i2s_sdout <= tx_shift[data_width-1];
          tx_shift  <= {tx_shift[data_width-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_sample_port.sv
module tb_i2s_sample_port;

`ifdef I2S_OUT_DUP_EN
  localparam bit dup = 1'b1;
`else
  localparam bit dup = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        i2s_bclk = 1'b0;
  logic        i2s_lrclk = 1'b0;
  logic        i2s_sdin = 1'b0;
  logic        i2s_sdout;
  logic [15:0] in_sample;
  logic        sample_valid;
  logic [15:0] out_sample = 16'h0000;
  logic        engine_ready = 1'b0;
  logic        underrun;

  i2s_sample_port #(.data_width(16), .slot_bits(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sdin     (i2s_sdin),
    .i2s_sdout    (i2s_sdout),
    .in_sample    (in_sample),
    .sample_valid (sample_valid),
    .out_sample   (out_sample),
    .engine_ready (engine_ready),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  logic [15:0] in_model = 16'h0000;
  logic [15:0] sv_q[$];
  longint      sv_t[$];
  longint      ur_t[$];
  bit          armed   = 1'b0;
  bit          fresh   = 1'b0;
  bit          tx_chk  = 1'b0;
  logic [15:0] hold_m  = 16'h0000;
  logic [15:0] tx_word = 16'h0000;
  logic [15:0] cap_left;
  logic [15:0] cap_right;
  int          sv_seen = 0;
  int          ur_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_latency(input string name, input longint lat);
    checks++;
    if (lat < 30 || lat > 40) begin
      errors++;
      $display("FAIL %s actual=%0d required=30..40 at %0t", name, lat, $time);
    end
  endtask

  // compare process: strobes, underrun pulses and held sample every cycle
  always @(negedge clk) begin
    if (sample_valid === 1'b1) begin
      sv_seen++;
      if (sv_q.size() == 0) begin
        check("sample_valid_unexpected", {31'b0, sample_valid}, 32'd0);
      end else begin
        check_latency("sample_valid_latency", $time - sv_t[0]);
        in_model = sv_q.pop_front();
        void'(sv_t.pop_front());
      end
    end else begin
      check("sample_valid_low", {31'b0, sample_valid}, 32'd0);
      if (sv_t.size() > 0 && ($time - sv_t[0]) > 40) begin
        check("sample_valid_missing", {31'b0, sample_valid}, 32'd1);
        void'(sv_q.pop_front());
        void'(sv_t.pop_front());
      end
    end
    check("in_sample", {16'b0, in_sample}, {16'b0, in_model});

    if (underrun === 1'b1) begin
      ur_seen++;
      if (ur_t.size() == 0) begin
        check("underrun_unexpected", {31'b0, underrun}, 32'd0);
      end else begin
        check_latency("underrun_latency", $time - ur_t[0]);
        void'(ur_t.pop_front());
      end
    end else begin
      check("underrun_low", {31'b0, underrun}, 32'd0);
      if (ur_t.size() > 0 && ($time - ur_t[0]) > 40) begin
        check("underrun_missing", {31'b0, underrun}, 32'd1);
        void'(ur_t.pop_front());
      end
    end
  end

  task automatic model_reset();
    armed    = 1'b0;
    fresh    = 1'b0;
    tx_chk   = 1'b0;
    hold_m   = 16'h0000;
    in_model = 16'h0000;
    sv_q.delete();
    sv_t.delete();
    ur_t.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_sample"},    {16'b0, in_sample},     32'd0);
    check({tag, "_sample_valid"}, {31'b0, sample_valid},  32'd0);
    check({tag, "_sdout"},        {31'b0, i2s_sdout},     32'd0);
    check({tag, "_underrun"},     {31'b0, underrun},      32'd0);
  endtask

  task automatic ready_pulse(input logic [15:0] v);
    @(negedge clk);
    out_sample   = v;
    engine_ready = 1'b1;
    hold_m       = v;
    fresh        = 1'b1;
    @(negedge clk);
    @(negedge clk);
    engine_ready = 1'b0;
    @(negedge clk);
  endtask

  // One I2S frame: left slot of left_len bclk cycles (cycle 0 is the delay
  // bit), then right slot of right_len cycles. word holds nbits MSB-first.
  // rst_at >= 0 pulls reset low during that left cycle, released 2 cycles later.
  task automatic frame(input logic [31:0] word, input int nbits, input int left_len,
                       input int right_len, input int rst_at);
    int          rx_bits;
    logic [15:0] rx_exp;
    logic        exp_bit;
    rx_bits   = left_len - 1;
    rx_exp    = 16'h0000;
    cap_left  = 16'h0000;
    cap_right = 16'h0000;
    for (int k = 1; k <= 16; k++)
      if (k <= rx_bits && k <= nbits) rx_exp[16-k] = word[nbits-k];

    for (int j = 0; j < left_len; j++) begin
      i2s_bclk  = 1'b0;
      i2s_lrclk = 1'b0;
      if (j >= 1 && j <= nbits) i2s_sdin = word[nbits-j];
      else                      i2s_sdin = 1'b0;
      if (j == rst_at) begin
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("midframe_reset");
        #77;
      end else if (rst_at >= 0 && j == rst_at + 2) begin
        #2;
        reset = 1'b1;
        #78;
      end else begin
        #80;
      end
      i2s_bclk = 1'b1;
      if (j == 0) begin
        if (armed) begin
          if (!fresh) ur_t.push_back($time);
          tx_word = hold_m;
          fresh   = 1'b0;
          tx_chk  = 1'b1;
        end else begin
          tx_chk = 1'b0;
        end
      end else if (tx_chk) begin
        exp_bit = (j <= 16) ? tx_word[16-j] : 1'b0;
        check("sdout_left", {31'b0, i2s_sdout}, {31'b0, exp_bit});
        if (j <= 16) cap_left[16-j] = i2s_sdout;
      end
      if (armed && j == 16 && rx_bits >= 16) begin
        sv_q.push_back(rx_exp);
        sv_t.push_back($time);
      end
      #80;
    end

    for (int j = 0; j < right_len; j++) begin
      i2s_bclk  = 1'b0;
      i2s_lrclk = 1'b1;
      i2s_sdin  = 1'($urandom_range(0, 1));
      #80;
      i2s_bclk = 1'b1;
      if (j == 0 && armed && rx_bits < 16) begin
        sv_q.push_back(rx_exp);
        sv_t.push_back($time);
      end
      if (j >= 1 && tx_chk) begin
        exp_bit = (dup && j <= 16) ? tx_word[16-j] : 1'b0;
        check("sdout_right", {31'b0, i2s_sdout}, {31'b0, exp_bit});
        if (j <= 16) cap_right[16-j] = i2s_sdout;
      end
      #80;
    end
    armed = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    int sv0;
    int ur0;
    reset = 1'b0;
    #25;
    check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // priming frame after reset: no clean 1->0 yet, so nothing is received
    sv0 = sv_seen;
    frame(32'h5555, 16, 32, 32, -1);
    check("prime_no_strobe", sv_seen - sv0, 0);

    // full 32-bit slots, fresh transmit sample
    ready_pulse(16'h5A5A);
    sv0 = sv_seen; ur0 = ur_seen;
    frame(32'h8123, 16, 32, 32, -1);
    check("lit_in_8123", {16'b0, in_sample}, 32'h8123);
    check("lit_tx_5a5a", {16'b0, cap_left}, 32'h5A5A);
    check("f2_one_strobe", sv_seen - sv0, 1);
    check("f2_no_underrun", ur_seen - ur0, 0);

    // short slot 12 bits, no new engine sample -> repeat + underrun
    sv0 = sv_seen; ur0 = ur_seen;
    frame(32'hABC, 12, 13, 32, -1);
    check("lit_in_abc0", {16'b0, in_sample}, 32'hABC0);
    check("lit_tx_repeat", {16'b0, cap_left}, 32'h5A50);
    check("f3_one_strobe", sv_seen - sv0, 1);
    check("f3_one_underrun", ur_seen - ur0, 1);

    // right slot content depends on duplication
    ready_pulse(16'h1234);
    frame(32'h7E01, 16, 32, 32, -1);
    check("lit_in_7e01", {16'b0, in_sample}, 32'h7E01);
    check("lit_tx_1234", {16'b0, cap_left}, 32'h1234);
    check("lit_right_slot", {16'b0, cap_right}, dup ? 32'h1234 : 32'h0000);

    // reset in the middle of the left slot
    sv0 = sv_seen;
    frame(32'hDEAD, 16, 32, 32, 8);
    check("reset_no_strobe", sv_seen - sv0, 0);
    check("reset_in_zero", {16'b0, in_sample}, 32'h0000);

    // first frame after the interrupted one is received normally
    ready_pulse(16'hC3A5);
    sv0 = sv_seen; ur0 = ur_seen;
    frame(32'h0F0F, 16, 32, 32, -1);
    check("lit_in_0f0f", {16'b0, in_sample}, 32'h0F0F);
    check("lit_tx_c3a5", {16'b0, cap_left}, 32'hC3A5);
    check("f6_one_strobe", sv_seen - sv0, 1);
    check("f6_no_underrun", ur_seen - ur0, 0);

    // left slot exactly data_width bits long
    sv0 = sv_seen; ur0 = ur_seen;
    frame(32'hFFFF, 16, 17, 32, -1);
    check("lit_in_ffff", {16'b0, in_sample}, 32'hFFFF);
    check("f7_one_strobe", sv_seen - sv0, 1);
    check("f7_one_underrun", ur_seen - ur0, 1);
    check("lit_tx_c3a5_repeat", {16'b0, cap_left}, 32'hC3A5);

    // 24-bit word in the slot: bits beyond data_width ignored
    ready_pulse(16'h0001);
    frame(32'h123456, 24, 32, 32, -1);
    check("lit_in_1234", {16'b0, in_sample}, 32'h1234);
    check("lit_tx_0001", {16'b0, cap_left}, 32'h0001);

    repeat (8) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
